// File: rtl/shift_exec_if.sv
// rtl/shift_exec_if.sv - issue/writeback handshake bundle for the shift execute stage
interface shift_exec_if #(
    parameter int RD_W = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [31:0]     in_a;
    logic [31:0]     in_shamt;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_res;
    logic [RD_W-1:0] out_rd;
    logic            out_z;
    logic            out_n;
    logic            out_c;

    modport master (
        output in_valid, in_op, in_a, in_shamt, in_rd, out_ready,
        input  in_ready, out_valid, out_res, out_rd, out_z, out_n, out_c
    );

    modport slave (
        input  in_valid, in_op, in_a, in_shamt, in_rd, out_ready,
        output in_ready, out_valid, out_res, out_rd, out_z, out_n, out_c
    );
endinterface

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-deep shift execute stage: operand register, shifter, result+flag register
module shift_exec_stage #(
    parameter bit SHAMT_MASK = 1'b1,
    parameter int RD_W       = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    shift_exec_if.slave  bus,
    output logic         busy
);
    logic            r_s1_valid;
    logic [1:0]      r_s1_op;
    logic [31:0]     r_s1_a;
    logic [31:0]     r_s1_shamt;
    logic [RD_W-1:0] r_s1_rd;

    logic            r_s2_valid;
    logic [31:0]     r_res;
    logic [RD_W-1:0] r_rd;
    logic            r_z;
    logic            r_n;
    logic            r_c;

    logic        w_s2_free;
    logic        w_adv;
    logic        w_in_ready;
    logic        w_accept;
    logic [31:0] w_k;
    logic [5:0]  w_k6;
    logic        w_zero;
    logic        w_ge32;
    logic        w_eq32;
    logic [4:0]  w_lidx;
    logic [4:0]  w_ridx;
    logic [31:0] w_res;
    logic        w_c;

    assign w_s2_free  = !r_s2_valid || bus.out_ready;
    assign w_adv      = r_s1_valid && w_s2_free;
    assign w_in_ready = !rst && !flush && (!r_s1_valid || w_s2_free);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_k        = SHAMT_MASK ? {27'b0, r_s1_shamt[4:0]} : r_s1_shamt;

    // Shifter; amounts of 32 and above only reach here when SHAMT_MASK=0.
    always_comb begin
        w_k6   = w_k[5:0];
        w_zero = (w_k == 32'd0);
        w_ge32 = |w_k[31:5];
        w_eq32 = (w_k == 32'd32);
        w_lidx = 5'(6'd32 - w_k6);
        w_ridx = 5'(w_k6 - 6'd1);
        w_res  = r_s1_a;
        w_c    = 1'b0;
        case (r_s1_op)
            2'b00: begin
                w_res = w_ge32 ? 32'd0 : (r_s1_a << w_k[4:0]);
                if (!w_zero && (!w_ge32 || w_eq32))
                    w_c = r_s1_a[w_lidx];
            end
            2'b10: begin
                w_res = w_ge32 ? 32'd0 : (r_s1_a >> w_k[4:0]);
                if (!w_zero && (!w_ge32 || w_eq32))
                    w_c = r_s1_a[w_ridx];
            end
            2'b11: begin
                w_res = w_ge32 ? {32{r_s1_a[31]}} : 32'($signed(r_s1_a) >>> w_k[4:0]);
                if (!w_zero)
                    w_c = (w_ge32 && !w_eq32) ? r_s1_a[31] : r_s1_a[w_ridx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 2'b0;
            r_s1_a     <= 32'd0;
            r_s1_shamt <= 32'd0;
            r_s1_rd    <= '0;
            r_s2_valid <= 1'b0;
            r_res      <= 32'd0;
            r_rd       <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
        end else if (flush) begin
            // Data registers hold so the writeback-facing outputs keep their last value.
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s2_valid <= 1'b1;
                r_res      <= w_res;
                r_rd       <= r_s1_rd;
                r_z        <= (w_res == 32'd0);
                r_n        <= w_res[31];
                r_c        <= w_c;
            end else if (bus.out_ready) begin
                r_s2_valid <= 1'b0;
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= bus.in_op;
                r_s1_a     <= bus.in_a;
                r_s1_shamt <= bus.in_shamt;
                r_s1_rd    <= bus.in_rd;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_res   = r_res;
    assign bus.out_rd    = r_rd;
    assign bus.out_z     = r_z;
    assign bus.out_n     = r_n;
    assign bus.out_c     = r_c;
    assign busy          = r_s1_valid || r_s2_valid;
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - bench for shift_exec_stage, masked and full-width shamt instances
module tb_shift_exec_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy_m;
    logic busy_u;

    always #5 clk = ~clk;

    shift_exec_if #(.RD_W(5)) ifm ();
    shift_exec_if #(.RD_W(5)) ifu ();

    shift_exec_stage #(.SHAMT_MASK(1'b1), .RD_W(5)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifm.slave), .busy(busy_m)
    );
    shift_exec_stage #(.SHAMT_MASK(1'b0), .RD_W(5)) dut_u (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifu.slave), .busy(busy_u)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic        c0;
        logic        c1;
        logic [4:0]  rd;
    } exp_t;

    logic [31:0] cap_res [2];
    logic [4:0]  cap_rd  [2];
    logic        cap_z   [2];
    logic        cap_n   [2];
    logic        cap_c   [2];
    int          lat;

    // Reference: place the operand in a 64-bit window and read the carry from the bit next to the result.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] shamt, input bit mask);
        logic [63:0]        x;
        logic signed [63:0] xs;
        int unsigned        k;
        k = mask ? 32'(shamt[4:0]) : shamt;
        if (k > 63) k = 63;
        case (op)
            2'b00: begin x = {32'b0, a} << k; return {x[32], x[31:0]}; end
            2'b01: return {1'b0, a};
            2'b10: begin x = {a, 32'b0} >> k; return {x[31], x[63:32]}; end
            default: begin xs = {a, 32'b0}; xs = xs >>> k; return {xs[31], xs[63:32]}; end
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] k, input logic [4:0] rd);
        ifm.in_valid = v; ifm.in_op = op; ifm.in_a = a; ifm.in_shamt = k; ifm.in_rd = rd;
        ifu.in_valid = v; ifu.in_op = op; ifu.in_a = a; ifu.in_shamt = k; ifu.in_rd = rd;
    endtask

    task automatic set_ready(input logic r);
        ifm.out_ready = r;
        ifu.out_ready = r;
    endtask

    task automatic capture();
        cap_res[0] = ifm.out_res; cap_rd[0] = ifm.out_rd; cap_z[0] = ifm.out_z;
        cap_n[0] = ifm.out_n; cap_c[0] = ifm.out_c;
        cap_res[1] = ifu.out_res; cap_rd[1] = ifu.out_rd; cap_z[1] = ifu.out_z;
        cap_n[1] = ifu.out_n; cap_c[1] = ifu.out_c;
    endtask

    // Issues one op into an empty pipe; lat counts negedges from the accepting edge to out_valid.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] k,
                         input logic [4:0] rd);
        drive(1'b1, op, a, k, rd);
        set_ready(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifm.in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (ifm.out_valid) break;
        end
        capture();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        set_ready(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({ifm.in_ready, ifu.in_ready} !== 2'b00) begin errors++;
            $display("FAIL reset_in_ready: got %b want 00", {ifm.in_ready, ifu.in_ready}); end
        checks++; if ({busy_m, ifm.out_valid, ifm.out_res, ifm.out_rd, ifm.out_z, ifm.out_n, ifm.out_c} !== '0) begin
            errors++; $display("FAIL reset_outputs_m: res=%h rd=%h v=%b", ifm.out_res, ifm.out_rd, ifm.out_valid); end
        checks++; if ({busy_u, ifu.out_valid, ifu.out_res, ifu.out_rd, ifu.out_z, ifu.out_n, ifu.out_c} !== '0) begin
            errors++; $display("FAIL reset_outputs_u: res=%h rd=%h v=%b", ifu.out_res, ifu.out_rd, ifu.out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({ifm.in_ready, ifu.in_ready} !== 2'b11) begin errors++;
            $display("FAIL post_reset_in_ready: got %b want 11", {ifm.in_ready, ifu.in_ready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_op(2'b00, 32'h0000_0001, 32'd4, 5'd3);
        checks++; if (lat !== 2) begin errors++;
            $display("FAIL basic_latency: got %0d want 2", lat); end
        for (int d = 0; d < 2; d++) begin
            checks++; if ({cap_res[d], cap_rd[d], cap_z[d], cap_c[d]} !== {32'h10, 5'd3, 1'b0, 1'b0}) begin
                errors++; $display("FAIL basic_sll dut%0d: res=%h rd=%0d z=%b c=%b want 10/3/0/0",
                                   d, cap_res[d], cap_rd[d], cap_z[d], cap_c[d]); end
        end
    endtask

    task automatic test_directed();
        do_op(2'b11, 32'h8000_0000, 32'd31, 5'd1);
        for (int d = 0; d < 2; d++) begin
            checks++; if ({cap_res[d], cap_n[d], cap_c[d]} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
                errors++; $display("FAIL sra31 dut%0d: res=%h n=%b c=%b want ffffffff/1/0",
                                   d, cap_res[d], cap_n[d], cap_c[d]); end
        end
        do_op(2'b10, 32'h8000_0001, 32'd1, 5'd2);
        for (int d = 0; d < 2; d++) begin
            checks++; if ({cap_res[d], cap_c[d]} !== {32'h4000_0000, 1'b1}) begin
                errors++; $display("FAIL srl1 dut%0d: res=%h c=%b want 40000000/1", d, cap_res[d], cap_c[d]); end
        end
    endtask

    task automatic test_width();
        logic [32:0] e;
        do_op(2'b11, 32'h8000_0000, 32'd40, 5'd4);
        checks++; if ({cap_res[1], cap_c[1]} !== {32'hFFFF_FFFF, 1'b1}) begin errors++;
            $display("FAIL sra40_full: res=%h c=%b want ffffffff/1", cap_res[1], cap_c[1]); end
        e = model(2'b11, 32'h8000_0000, 32'd40, 1'b1);
        checks++; if ({cap_c[0], cap_res[0]} !== e) begin errors++;
            $display("FAIL sra40_masked: res=%h c=%b want %h/%b", cap_res[0], cap_c[0], e[31:0], e[32]); end
        do_op(2'b00, 32'hFFFF_FFFF, 32'd32, 5'd5);
        checks++; if ({cap_res[1], cap_z[1], cap_c[1]} !== {32'd0, 1'b1, 1'b1}) begin errors++;
            $display("FAIL sll32_full: res=%h z=%b c=%b want 0/1/1", cap_res[1], cap_z[1], cap_c[1]); end
        checks++; if ({cap_res[0], cap_z[0], cap_c[0]} !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin errors++;
            $display("FAIL sll32_masked: res=%h z=%b c=%b want ffffffff/0/0", cap_res[0], cap_z[0], cap_c[0]); end
    endtask

    // Streams n ops; rnd=0 uses a fixed 3-cycle out_ready stall, rnd=1 randomises valid, ready and operands.
    task automatic test_back_to_back(input int n, input bit rnd);
        exp_t        q[$];
        exp_t        e;
        int          sent = 0, got = 0, occ = 0, cyc = 0;
        logic        v = 1'b0, held = 1'b0, acc, del, stall = 1'b0, exp_rdy;
        logic [31:0] pres = 32'd0;
        logic [1:0]  op = 2'b00;
        logic [31:0] a = 32'd0, k = 32'd0;
        logic [4:0]  rd = 5'd0;
        logic [32:0] m0, m1;
        flush = 1'b0;
        while (got < n && cyc < 2000) begin
            if (!held) begin
                if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                    v = 1'b1; op = 2'($urandom); a = $urandom; rd = 5'($urandom);
                    k = (rnd && $urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                end else begin
                    v = 1'b0;
                end
            end
            drive(v, op, a, k, rd);
            set_ready(rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc < 6));
            @(negedge clk);
            acc = v & ifm.in_ready;
            del = ifm.out_valid & ifm.out_ready;
            exp_rdy = (occ < 2) || ifm.out_ready;
            checks++; if ({ifm.in_ready, ifu.in_ready} !== {exp_rdy, exp_rdy}) begin errors++;
                $display("FAIL stream_in_ready cyc%0d: got %b want %b", cyc, {ifm.in_ready, ifu.in_ready}, exp_rdy); end
            if (stall) begin
                checks++; if (ifm.out_valid !== 1'b1 || ifm.out_res !== pres) begin errors++;
                    $display("FAIL stream_hold cyc%0d: v=%b res=%h want 1/%h", cyc, ifm.out_valid, ifm.out_res, pres); end
            end
            if (del) begin
                capture();
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra cyc%0d: got res=%h want nothing", cyc, cap_res[0]);
                end else begin
                    e = q.pop_front();
                    if ({cap_res[0], cap_c[0], cap_z[0], cap_n[0], cap_rd[0]} !== {e.r0, e.c0, e.r0 == 0, e.r0[31], e.rd} ||
                        {cap_res[1], cap_c[1], cap_z[1], cap_n[1], cap_rd[1]} !== {e.r1, e.c1, e.r1 == 0, e.r1[31], e.rd}) begin
                        errors++;
                        $display("FAIL stream_data #%0d: got %h/%b %h/%b rd=%0d want %h/%b %h/%b rd=%0d", got,
                                 cap_res[0], cap_c[0], cap_res[1], cap_c[1], cap_rd[0], e.r0, e.c0, e.r1, e.c1, e.rd);
                    end
                end
                got++;
            end
            if (acc) begin
                m0 = model(op, a, k, 1'b1);
                m1 = model(op, a, k, 1'b0);
                q.push_back('{r0: m0[31:0], r1: m1[31:0], c0: m0[32], c1: m1[32], rd: rd});
                sent++;
            end
            occ = occ + int'(acc) - int'(del);
            stall = ifm.out_valid & !ifm.out_ready;
            pres = ifm.out_res;
            held = v & !acc;
            cyc++;
            @(posedge clk); #1;
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        set_ready(1'b1);
        checks++; if (got !== n || q.size() != 0) begin errors++;
            $display("FAIL stream_count: delivered %0d pending %0d want %0d/0", got, q.size(), n); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        set_ready(1'b0);
        drive(1'b1, 2'b00, 32'h1, 32'd1, 5'd1);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 32'h80, 32'd2, 5'd2);
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 32'h55, 32'd3, 5'd9);
        flush = 1'b1;
        @(negedge clk);
        checks++; if ({ifm.in_ready, busy_m, ifm.out_valid} !== 3'b011) begin errors++;
            $display("FAIL flush_cycle: in_ready/busy/out_valid=%b want 011", {ifm.in_ready, busy_m, ifm.out_valid}); end
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        set_ready(1'b1);
        @(negedge clk);
        checks++; if ({busy_m, ifm.out_valid, busy_u, ifu.out_valid} !== 4'b0000) begin errors++;
            $display("FAIL flush_after: busy/valid=%b want 0000", {busy_m, ifm.out_valid, busy_u, ifu.out_valid}); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if ({ifm.out_valid, ifu.out_valid} !== 2'b00) begin errors++;
                $display("FAIL flush_ghost cyc%0d: out_valid=%b rd=%0d want 00", i, {ifm.out_valid, ifu.out_valid}, ifm.out_rd); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_pass_reset();
        do_op(2'b01, 32'h1234_5678, 32'd7, 5'd6);
        for (int d = 0; d < 2; d++) begin
            checks++; if ({cap_res[d], cap_c[d], cap_rd[d]} !== {32'h1234_5678, 1'b0, 5'd6}) begin errors++;
                $display("FAIL pass dut%0d: res=%h c=%b want 12345678/0", d, cap_res[d], cap_c[d]); end
        end
        set_ready(1'b1);
        drive(1'b1, 2'b00, 32'hDEAD_BEEF, 32'd1, 5'd7);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 32'hCAFE_F00D, 32'd4, 5'd8);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ifm.in_ready, ifu.in_ready} !== 2'b00) begin errors++;
            $display("FAIL midrst_in_ready: got %b want 00", {ifm.in_ready, ifu.in_ready}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({busy_m, ifm.out_valid, ifm.out_res, ifm.out_rd, ifm.out_z, ifm.out_n, ifm.out_c} !== '0 ||
                      {busy_u, ifu.out_valid, ifu.out_res, ifu.out_rd, ifu.out_z, ifu.out_n, ifu.out_c} !== '0) begin
            errors++; $display("FAIL midrst_outputs: v=%b res=%h busy=%b want all 0", ifm.out_valid, ifm.out_res, busy_m); end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({ifm.in_ready, busy_m, ifm.out_valid} !== 3'b100) begin errors++;
            $display("FAIL midrst_recover: in_ready/busy/valid=%b want 100", {ifm.in_ready, busy_m, ifm.out_valid}); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_width();
        test_back_to_back(4, 1'b0);
        test_flush();
        test_pass_reset();
        test_back_to_back(200, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
